// File: rtl/johnson_counter_pkg.sv
// Shared helpers for the Johnson counter: legality test and sequence period.
package johnson_counter_pkg;

    localparam int unsigned MAX_N = 64;

    function automatic int unsigned period(input int unsigned n);
        return 2 * n;
    endfunction

    // Legal when the low n bits are a low-ones mask (0..01..1, including 0)
    // or their complement is one (1..10..0).
    function automatic logic is_johnson(input logic [MAX_N-1:0] v, input int unsigned n);
        logic [MAX_N-1:0] mask;
        logic [MAX_N-1:0] lo;
        logic [MAX_N-1:0] hi;
        mask = (n >= MAX_N) ? '1 : ((MAX_N'(1) << n) - MAX_N'(1));
        lo   = v & mask;
        hi   = ~v & mask;
        return ((lo & (lo + MAX_N'(1))) == '0) || ((hi & (hi + MAX_N'(1))) == '0);
    endfunction

endpackage

// File: rtl/johnson_counter_dff.sv
// 1-bit rising-edge D flip-flop with synchronous active-high reset to 0.
module d_flipflop (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= 1'b0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/johnson_counter.sv
// N-bit Johnson (twisted-ring) counter with wrap flag and illegal-code recovery.
module johnson_counter
    import johnson_counter_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [N-1:0] q,
    output logic         wrap,
    output logic         illegal
);

    logic [N-1:0] q_d;

    assign illegal = ~is_johnson(MAX_N'(q), N);
    assign wrap    = en && (q == {1'b1, {(N-1){1'b0}}});

    // Reset lives in the flops; correction to 0 outranks the shift.
    always_comb begin
        q_d = q;
        if (en) begin
            if (illegal) begin
                q_d = '0;
            end else begin
                q_d = {q[N-2:0], ~q[N-1]};
            end
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_ff
        d_flipflop u_ff (
            .clk   (clk),
            .reset (reset),
            .d     (q_d[i]),
            .q     (q[i])
        );
    end

endmodule

// File: tb/tb_johnson_counter.sv
// Scoreboard bench for johnson_counter at N=8 and N=2 against a table-driven model.
module tb_johnson_counter;
    import johnson_counter_pkg::*;

    typedef struct packed {
        logic [7:0] q;
        logic       wrap;
        logic       ill;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       en8;
    logic       en2;
    logic [7:0] q8;
    logic       wrap8;
    logic       ill8;
    logic [1:0] q2;
    logic       wrap2;
    logic       ill2;

    exp_t sb8[$];
    exp_t sb2[$];
    int   tests;
    int   fails;
    logic [7:0] m8;
    logic [7:0] m2;

    johnson_counter #(.N(8)) u8 (
        .clk(clk), .reset(reset), .en(en8), .q(q8), .wrap(wrap8), .illegal(ill8)
    );

    johnson_counter #(.N(2)) u2 (
        .clk(clk), .reset(reset), .en(en2), .q(q2), .wrap(wrap2), .illegal(ill2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // k-th code of the 2n-state sequence: k ones filled from bit 0, then
    // zeros filled from bit 0 underneath the all-ones word.
    function automatic logic [7:0] code_at(input int unsigned k, input int unsigned n);
        logic [7:0] full;
        full = (8'(1) << n) - 8'(1);
        if (k <= n) return (8'(1) << k) - 8'(1);
        return full & ~((8'(1) << (k - n)) - 8'(1));
    endfunction

    function automatic int find_idx(input logic [7:0] v, input int unsigned n);
        for (int unsigned k = 0; k < period(n); k++) begin
            if (code_at(k, n) === v) return int'(k);
        end
        return -1;
    endfunction

    function automatic logic [7:0] nxt(input logic [7:0] v, input logic r, input logic e,
                                       input int unsigned n);
        int idx;
        if (r) return 8'h00;
        if (!e) return v;
        idx = find_idx(v, n);
        if (idx < 0) return 8'h00;
        return code_at((int'(idx) + 1) % period(n), n);
    endfunction

    task automatic push_exp(input logic e8, input logic e2);
        exp_t x;
        x.q    = m8;
        x.wrap = e8 && (m8 == 8'h80);
        x.ill  = (find_idx(m8, 8) < 0);
        sb8.push_back(x);
        x.q    = m2;
        x.wrap = e2 && (m2 == 8'h02);
        x.ill  = (find_idx(m2, 2) < 0);
        sb2.push_back(x);
    endtask

    task automatic step(input logic r, input logic e8, input logic e2);
        @(negedge clk);
        reset = r;
        en8   = e8;
        en2   = e2;
        m8    = nxt(m8, r, e8, 8);
        m2    = nxt(m2, r, e2, 2);
        push_exp(e8, e2);
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb8.size() > 0) begin
                e = sb8.pop_front();
                chk("q8", q8, e.q);
                chk("wrap8", {7'd0, wrap8}, {7'd0, e.wrap});
                chk("illegal8", {7'd0, ill8}, {7'd0, e.ill});
            end
            if (sb2.size() > 0) begin
                e = sb2.pop_front();
                chk("q2", {6'd0, q2}, e.q);
                chk("wrap2", {7'd0, wrap2}, {7'd0, e.wrap});
                chk("illegal2", {7'd0, ill2}, {7'd0, e.ill});
            end
        end
    end

    initial begin : driver
        int guard;
        tests = 0;
        fails = 0;
        reset = 1'b1;
        en8   = 1'b1;
        en2   = 1'b1;
        m8    = 8'hxx;
        m2    = 8'hxx;

        // Reset for 3 edges with enable high, then one full period and 48 more.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 16 + 48; i++) step(1'b0, 1'b1, 1'b1);

        // Hold at 3F for 5 cycles, then resume.
        guard = 0;
        while (m8 != 8'h3F && guard < 40) begin
            step(1'b0, 1'b1, 1'b1);
            guard++;
        end
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1);

        // Single-edge reset at FC.
        guard = 0;
        while (m8 != 8'hFC && guard < 40) begin
            step(1'b0, 1'b1, 1'b1);
            guard++;
        end
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);

        // Plant illegal 5A through the next-state path, then hold and recover.
        @(negedge clk);
        force u8.q_d = 8'h5A;
        reset = 1'b0;
        en8   = 1'b0;
        en2   = 1'b1;
        m8    = 8'h5A;
        m2    = nxt(m2, 1'b0, 1'b1, 2);
        push_exp(1'b0, 1'b1);
        @(posedge clk);
        #2;
        release u8.q_d;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b1);

        // Randomised enable and occasional reset.
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3) != 0);
        end

        @(posedge clk);
        @(posedge clk);
        #2;
        chk("drain8", 8'(sb8.size()), 8'd0);
        chk("drain2", 8'(sb2.size()), 8'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
